// File: rtl/riscv_32i_defs_pkg.sv
// riscv_32i_defs_pkg
// Shared RV32I datapath definitions: word and register-address types, the
// register-file geometry, and the types used by the register-file write
// controller (a pending write request and the controller FSM states).
// No ports; imported by the register-file write controller files.

package riscv_32i_defs_pkg;

   localparam int XLEN     = 32;
   localparam int RF_DEPTH = 32;

   typedef logic [XLEN-1:0]             word_t;
   typedef logic [$clog2(RF_DEPTH)-1:0] rf_addr_t;

   // x0 is hard-wired to zero, so writes to it are dropped
   localparam rf_addr_t X0 = '0;

   // One pending register-file write. The destination field cannot be
   // called "reg" because that is a reserved word, hence "addr".
   typedef struct packed {
      rf_addr_t addr;
      word_t    data;
   } wr_req_t;

   typedef enum logic {
      WR_INIT,
      WR_RUN
   } wr_ctrl_state_t;

endpackage

// File: rtl/reg_file_wr_ctrl_if.sv
// reg_file_wr_ctrl_if
// Bundles every signal of the register-file write controller apart from
// clock and reset: the ALU and load writeback handshakes, the register-file
// write port, the two pending-query ports and the init-done flag.
// Modports:
//   master - the write controller (takes requests, drives the write port)
//   slave  - the datapath / register file side

interface reg_file_wr_ctrl_if;
   import riscv_32i_defs_pkg::*;

   logic     alu_wr_valid;
   rf_addr_t alu_wr_reg;
   word_t    alu_wr_data;
   logic     alu_wr_ready;

   logic     mem_wr_valid;
   rf_addr_t mem_wr_reg;
   word_t    mem_wr_data;
   logic     mem_wr_ready;

   logic     wr_en;
   rf_addr_t wr_reg;
   word_t    wr_data;

   rf_addr_t rd_reg_1;
   rf_addr_t rd_reg_2;
   logic     pend_hit_1;
   logic     pend_hit_2;
   word_t    pend_data_1;
   word_t    pend_data_2;

   logic     init_done;

   modport master (
      input  alu_wr_valid, alu_wr_reg, alu_wr_data,
      output alu_wr_ready,
      input  mem_wr_valid, mem_wr_reg, mem_wr_data,
      output mem_wr_ready,
      output wr_en, wr_reg, wr_data,
      input  rd_reg_1, rd_reg_2,
      output pend_hit_1, pend_hit_2, pend_data_1, pend_data_2,
      output init_done
   );

   modport slave (
      output alu_wr_valid, alu_wr_reg, alu_wr_data,
      input  alu_wr_ready,
      output mem_wr_valid, mem_wr_reg, mem_wr_data,
      input  mem_wr_ready,
      input  wr_en, wr_reg, wr_data,
      output rd_reg_1, rd_reg_2,
      input  pend_hit_1, pend_hit_2, pend_data_1, pend_data_2,
      input  init_done
   );

endinterface

// File: rtl/reg_file_wr_fifo.sv
// reg_file_wr_fifo
// Pending-write FIFO for the register-file write controller. Holds the
// accepted but not yet issued writes and exposes its whole storage plus a
// valid mask so the controller can search it for bypass data.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset (flushes everything)
//   push_i       - enqueue pushData_i (ignored when full)
//   pushData_i   - request to enqueue
//   pop_i        - dequeue the head (ignored when empty)
//   head_o       - oldest entry
//   count_o      - number of valid entries
//   wrPtr_o      - slot the next push lands in (youngest entry is wrPtr_o-1)
//   entries_o    - raw storage, indexed by slot
//   valid_o      - per-slot valid mask

module reg_file_wr_fifo
   import riscv_32i_defs_pkg::*;
#(
   parameter  int FIFO_DEPTH = 4,
   localparam int PW         = $clog2(FIFO_DEPTH),
   localparam int CW         = PW + 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push_i,
   input  wr_req_t                        pushData_i,
   input  logic                           pop_i,
   output wr_req_t                        head_o,
   output logic    [CW-1:0]               count_o,
   output logic    [PW-1:0]               wrPtr_o,
   output wr_req_t [FIFO_DEPTH-1:0]       entries_o,
   output logic    [FIFO_DEPTH-1:0]       valid_o
);

   wr_req_t [FIFO_DEPTH-1:0] mem_q;
   logic    [PW-1:0]         wrPtr_q;
   logic    [PW-1:0]         rdPtr_q;
   logic    [CW-1:0]         count_q;
   logic                     doPush;
   logic                     doPop;

   assign doPush = push_i && (count_q != CW'(FIFO_DEPTH));
   assign doPop  = pop_i && (count_q != '0);

   // Storage, pointers and occupancy. Pointers wrap naturally because the
   // depth is a power of two; a simultaneous push and pop keeps the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q   <= '0;
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
            wrPtr_q        <= wrPtr_q + 1'b1;
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // A slot is valid when its distance from the read pointer is below the
   // occupancy; this also covers the wrapped case.
   always_comb begin
      valid_o = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         logic [PW-1:0] offset;
         offset     = PW'(i) - rdPtr_q;
         valid_o[i] = ({1'b0, offset} < count_q);
      end
   end

   assign head_o    = mem_q[rdPtr_q];
   assign count_o   = count_q;
   assign wrPtr_o   = wrPtr_q;
   assign entries_o = mem_q;

endmodule

// File: rtl/reg_file_wr_ctrl.sv
// reg_file_wr_ctrl
// Write-side controller for the register file. After reset it clears
// x1..x31 one per cycle, then merges ALU and load writebacks (ALU has fixed
// priority) through a pending FIFO onto the single registered write port,
// and answers two combinational pending queries for bypassing.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   bus      - reg_file_wr_ctrl_if.master: writeback handshakes, write port,
//              pending queries and init_done

module reg_file_wr_ctrl
   import riscv_32i_defs_pkg::*;
#(
   parameter  int FIFO_DEPTH = 4,
   localparam int PW         = $clog2(FIFO_DEPTH),
   localparam int CW         = PW + 1
) (
   input  logic                clk,
   input  logic                rst,
   reg_file_wr_ctrl_if.master  bus
);

   typedef struct packed {
      logic  hit;
      word_t data;
   } pend_t;

   wr_ctrl_state_t state_q, state_d;
   rf_addr_t       idx_q, idx_d;
   logic           wrEn_q, wrEn_d;
   rf_addr_t       wrReg_q, wrReg_d;
   word_t          wrData_q, wrData_d;
   logic           initDone_q, initDone_d;

   logic                     aluReady;
   logic                     memReady;
   logic                     push;
   wr_req_t                  pushData;
   logic                     pop;
   wr_req_t                  fifoHead;
   logic    [CW-1:0]         fifoCount;
   logic    [PW-1:0]         fifoWrPtr;
   wr_req_t [FIFO_DEPTH-1:0] fifoEntries;
   logic    [FIFO_DEPTH-1:0] fifoValid;
   pend_t                    pend1;
   pend_t                    pend2;

   reg_file_wr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push),
      .pushData_i (pushData),
      .pop_i      (pop),
      .head_o     (fifoHead),
      .count_o    (fifoCount),
      .wrPtr_o    (fifoWrPtr),
      .entries_o  (fifoEntries),
      .valid_o    (fifoValid)
   );

   // State register plus the registered write port and clear index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= WR_INIT;
         idx_q      <= rf_addr_t'(1);
         wrEn_q     <= 1'b0;
         wrReg_q    <= X0;
         wrData_q   <= '0;
         initDone_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         wrEn_q     <= wrEn_d;
         wrReg_q    <= wrReg_d;
         wrData_q   <= wrData_d;
         initDone_q <= initDone_d;
      end
   end

   // Leave the clear sequence on the edge that writes the last register.
   always_comb begin
      state_d = state_q;
      if (state_q == WR_INIT && idx_q == rf_addr_t'(RF_DEPTH - 1)) begin
         state_d = WR_RUN;
      end
   end

   // Outputs and datapath controls. Readiness looks only at the registered
   // count, so a full FIFO stays closed even if it pops this cycle. Writes
   // to x0 still handshake but never enter the FIFO.
   always_comb begin
      idx_d      = idx_q;
      wrEn_d     = 1'b0;
      wrReg_d    = wrReg_q;
      wrData_d   = wrData_q;
      initDone_d = initDone_q;
      aluReady   = 1'b0;
      memReady   = 1'b0;
      push       = 1'b0;
      pushData   = '0;
      pop        = 1'b0;
      case (state_q)
         WR_INIT: begin
            wrEn_d   = 1'b1;
            wrReg_d  = idx_q;
            wrData_d = '0;
            idx_d    = idx_q + 1'b1;
            if (idx_q == rf_addr_t'(RF_DEPTH - 1)) begin
               initDone_d = 1'b1;
            end
         end
         WR_RUN: begin
            aluReady = (fifoCount < CW'(FIFO_DEPTH));
            memReady = aluReady && !bus.alu_wr_valid;
            if (bus.alu_wr_valid && aluReady) begin
               push     = (bus.alu_wr_reg != X0);
               pushData = '{addr: bus.alu_wr_reg, data: bus.alu_wr_data};
            end else if (bus.mem_wr_valid && memReady) begin
               push     = (bus.mem_wr_reg != X0);
               pushData = '{addr: bus.mem_wr_reg, data: bus.mem_wr_data};
            end
            pop = (fifoCount != '0);
            if (pop) begin
               wrEn_d   = 1'b1;
               wrReg_d  = fifoHead.addr;
               wrData_d = fifoHead.data;
            end
         end
         default: begin
         end
      endcase
   end

   // The output register holds the oldest uncommitted write, so it is checked
   // first; FIFO slots are then scanned oldest to youngest and each match
   // overrides, leaving the youngest data.
   function automatic pend_t pendLookup(
      input rf_addr_t                 rd,
      input wr_req_t [FIFO_DEPTH-1:0] ents,
      input logic    [FIFO_DEPTH-1:0] vld,
      input logic    [PW-1:0]         wptr,
      input logic                     outEn,
      input rf_addr_t                 outReg,
      input word_t                    outData
   );
      pend_t         res;
      logic [PW-1:0] slot;
      res = '0;
      if (rd != X0) begin
         if (outEn && outReg == rd) begin
            res.hit  = 1'b1;
            res.data = outData;
         end
         for (int i = FIFO_DEPTH; i >= 1; i--) begin
            slot = wptr - PW'(i);
            if (vld[slot] && ents[slot].addr == rd) begin
               res.hit  = 1'b1;
               res.data = ents[slot].data;
            end
         end
      end
      return res;
   endfunction

   always_comb begin
      pend1 = pendLookup(bus.rd_reg_1, fifoEntries, fifoValid, fifoWrPtr,
                         wrEn_q, wrReg_q, wrData_q);
      pend2 = pendLookup(bus.rd_reg_2, fifoEntries, fifoValid, fifoWrPtr,
                         wrEn_q, wrReg_q, wrData_q);
   end

   assign bus.alu_wr_ready = aluReady;
   assign bus.mem_wr_ready = memReady;
   assign bus.wr_en        = wrEn_q;
   assign bus.wr_reg       = wrReg_q;
   assign bus.wr_data      = wrData_q;
   assign bus.init_done    = initDone_q;
   assign bus.pend_hit_1   = pend1.hit;
   assign bus.pend_data_1  = pend1.data;
   assign bus.pend_hit_2   = pend2.hit;
   assign bus.pend_data_2  = pend2.data;

endmodule
